// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad front end: key codes, debounce states.
package calc_pkg;

  localparam int unsigned KEY_W = 4;

  // Keypad codes as delivered to the calculator core.
  typedef enum logic [KEY_W-1:0] {
    KEY_0   = 4'd0,
    KEY_1   = 4'd1,
    KEY_2   = 4'd2,
    KEY_3   = 4'd3,
    KEY_4   = 4'd4,
    KEY_5   = 4'd5,
    KEY_6   = 4'd6,
    KEY_7   = 4'd7,
    KEY_8   = 4'd8,
    KEY_9   = 4'd9,
    KEY_ADD = 4'd10,
    KEY_SUB = 4'd11,
    KEY_MUL = 4'd12,
    KEY_DIV = 4'd13,
    KEY_EQ  = 4'd14,
    KEY_CLR = 4'd15
  } key_code_e;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_W = 2'd1,
    HELD    = 2'd2,
    REL_W   = 2'd3
  } deb_state_e;

endpackage

// File: rtl/calc_key_fifo.sv
// Small synchronous FIFO with a registered head (no write-to-output bypass).
module calc_key_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     head_q, head_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  // Pointer/count update; head is precomputed from the post-edge read pointer,
  // taking the incoming word when that slot is being written this cycle.
  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_d   = head_q;
    if (count_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = data_i;
      else                                    head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are only read when the count says they are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/calc_key_input.sv
// Keypad front end: 2-flop synchroniser, debounce FSM, key event FIFO.
// Optional auto-repeat while a key is held: define KEY_AUTOREPEAT_EN.
module calc_key_input
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 4096,
  parameter int unsigned REPEAT_PERIOD   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_code_i,
  input  logic             key_press_i,
  input  logic             key_ready_i,
  output logic             key_valid_o,
  output logic [KEY_W-1:0] key_code_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic             sp_meta_q, sp_q;
  logic [KEY_W-1:0] sc_meta_q, sc_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  key_code_e        cand_q, cand_d;
  logic             deb_push, rpt_push, push_evt, pop, fifo_full, fifo_empty;
  logic             overflow_q, overflow_d;

  // Two-flop synchronisers for the asynchronous keypad pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_meta_q <= 1'b0;
      sp_q      <= 1'b0;
      sc_meta_q <= '0;
      sc_q      <= '0;
    end else begin
      sp_meta_q <= key_press_i;
      sp_q      <= sp_meta_q;
      sc_meta_q <= key_code_i;
      sc_q      <= sc_meta_q;
    end
  end

  // Debounce next-state: cnt counts consecutive qualifying samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    deb_push = 1'b0;
    cnt_inc  = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (sp_q) begin
          state_d = PRESS_W;
          cnt_d   = CNT_W'(1);
          cand_d  = key_code_e'(sc_q);
        end
      end
      PRESS_W: begin
        if (!sp_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sc_q != cand_q) begin
          cand_d = key_code_e'(sc_q);
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d  = HELD;
            cnt_d    = '0;
            deb_push = 1'b1;
          end
        end
      end
      HELD: begin
        if (!sp_q) begin
          state_d = REL_W;
          cnt_d   = CNT_W'(1);
        end
      end
      REL_W: begin
        if (sp_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc;
  logic             rpt_started_q, rpt_started_d;

  // Repeat timer: runs only while staying in HELD, so any entry into HELD
  // (fresh accept or release bounce) restarts the initial delay.
  always_comb begin
    rpt_cnt_d     = '0;
    rpt_started_d = 1'b0;
    rpt_push      = 1'b0;
    rpt_inc       = rpt_cnt_q + RPT_W'(1);
    if ((state_q == HELD) && (state_d == HELD)) begin
      rpt_cnt_d     = rpt_inc;
      rpt_started_d = rpt_started_q;
      if ((!rpt_started_q && (rpt_inc == RPT_W'(REPEAT_DELAY))) ||
          ( rpt_started_q && (rpt_inc == RPT_W'(REPEAT_PERIOD)))) begin
        rpt_push      = 1'b1;
        rpt_cnt_d     = '0;
        rpt_started_d = 1'b1;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q     <= '0;
      rpt_started_q <= 1'b0;
    end else begin
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_started_q <= rpt_started_d;
    end
  end
`else
  if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end
  assign rpt_push = 1'b0;
`endif

  assign push_evt    = deb_push | rpt_push;
  assign key_valid_o = ~fifo_empty;
  assign pop         = key_valid_o & key_ready_i;
  assign overflow_o  = overflow_q;

  // A push is lost only when full and nothing leaves on the same edge.
  always_comb begin
    overflow_d = overflow_q | (push_evt & fifo_full & ~pop);
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  calc_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_evt),
    .data_i  (cand_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (key_code_o)
  );

endmodule
